fifo_interleave_n: RTL
======================

// Module: fifo_interleave_n
// PURPOSE
//  N-way generalisation of the two-element ping-pong FIFO pair.
//  NBANKS independent FIFO banks, each DEPTH deep, sit behind one PipeIn/PipeOut-style enq/deq interface.
//  Successive enqueues rotate round-robin across banks, and successive dequeues rotate in the same order, so global FIFO order is preserved.
//  Adds a flush, an occupancy count and a per-port stall view for throughput debug in the echo datapath.
// PARAMETERS
//  WIDTH   704  payload width in bits (>=1)
//  NBANKS  2    number of banks (>=1; any value, not only powers of 2)
//  DEPTH   1    entries per bank (>=1)
//  CW      $clog2(NBANKS*DEPTH+1)  width of count output (derived, not overridable)
// PORTS
//  CLK            in   1      clock; all state on posedge
//  RST            in   1      reset, synchronous and active-high
//  enq__ENA       in   1      enqueue request; honoured only when enq__RDY=1
//  enq_v          in   WIDTH  enqueue payload
//  enq__RDY       out  1      target bank wr_sel not full
//  deq__ENA       in   1      dequeue request; honoured only when deq__RDY=1
//  deq__RDY       out  1      source bank rd_sel not empty
//  first          out  WIDTH  head of bank rd_sel; 0 when that bank is empty
//  first__RDY     out  1      equals deq__RDY
//  flush          in   1      discard all contents; synchronous, 1-cycle pulse sufficient
//  count          out  CW     total entries held across all banks
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  State:
//   - wr_sel, rd_sel in [0,NBANKS-1].
//   - Per bank: head/tail ptrs and occupancy 0..DEPTH.
//   - count register.
//  Reset (RST=1 at posedge):
//   - wr_sel=rd_sel=0; all banks empty; count=0.
//   - While RST=1: enq__RDY=0, deq__RDY=first__RDY=0, first=0; ENA inputs ignored.
//   - RST mid-stream drops all data; no partial state survives.
//  Enq fire (enq__ENA && enq__RDY):
//   - Write enq_v to bank[wr_sel] tail.
//   - wr_sel <= (wr_sel==NBANKS-1) ? 0 : wr_sel+1.
//  Deq fire (deq__ENA && deq__RDY):
//   - Pop bank[rd_sel] head.
//   - rd_sel advances with the same wrap rule.
//  Ready/output: all combinational from registered state only; no enq->deq bypass, no deq->enq pass-through.
//   - Enq into an empty bank: first/deq__RDY become valid the next cycle (latency 1).
//   - Full bank with deq of that bank in the same cycle: enq__RDY stays 0 that cycle.
//  Simultaneous enq+deq fire:
//   - Both take effect; count unchanged.
//   - This holds even when wr_sel==rd_sel (bank occupancy unchanged).
//  count:
//   - +1 on enq only, -1 on deq only; never exceeds NBANKS*DEPTH, never underflows.
//  Ordering: item k enqueued after reset/flush lands in bank k mod NBANKS; dequeue returns items in enqueue order.
//  Flush (flush=1, RST=0):
//   - Same end state as reset.
//   - Ready outputs remain state-derived during the flush cycle.
//   - Any enq/deq fire in that cycle is discarded; flush has priority.
//  Illegal ENA while RDY=0 is ignored, with no state change.
//  NBANKS=1 degenerates to a plain DEPTH-deep FIFO with identical ports.
// TESTING
//  T1 reset:
//   - Hold RST 2 cycles with enq__ENA=1 -> enq__RDY=0, count=0.
//   - After release -> enq__RDY=1, deq__RDY=0, first=0.
//  T2 order (NBANKS=3, DEPTH=2):
//   - Enq 1..6 back-to-back -> enq__RDY=0 after the 6th, count=6.
//   - Deq all -> first sequence 1,2,3,4,5,6.
//  T3 streaming:
//   - Enq and deq every cycle for 100 cycles after 1 priming enq -> count stays 1.
//   - Output equals input delayed, no bubbles.
//  T4 full-bank stall:
//   - NBANKS=2, DEPTH=1: enq A,B -> full.
//   - Deq (gets A) with enq C same cycle -> C rejected that cycle.
//   - C accepted next cycle into bank0.
//  T5 flush:
//   - Fill 3 entries, assert flush with deq__ENA=1 -> count=0, deq__RDY=0 next cycle.
//   - Subsequent enq X -> first=X from bank0.
//  T6 wrap (NBANKS=5):
//   - 23 enq/deq pairs interleaved -> rd_sel/wr_sel wrap 4->0 correctly.
//   - Data matches a reference queue.

Source files
------------

// File: rtl/fifo_interleave_n.sv
// fifo_interleave_n: NBANKS round-robin FIFO banks behind one enq/deq port pair.
// Enqueues and dequeues rotate through the banks in the same order, so the
// global FIFO order is preserved while each bank only sees every NBANKS-th item.
module fifo_interleave_n #(
  parameter  int unsigned WIDTH  = 704,
  parameter  int unsigned NBANKS = 2,
  parameter  int unsigned DEPTH  = 1,
  localparam int unsigned CW     = $clog2(NBANKS*DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             enq__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [WIDTH-1:0] first,
  output logic             first__RDY,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  // Selector / pointer widths; arrays are padded to a power of two so every
  // index expression is exactly as wide as the array it addresses.
  localparam int unsigned SW  = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW  = $clog2(DEPTH+1);
  localparam int unsigned NB2 = 1 << SW;
  localparam int unsigned MD  = 1 << PW;

  logic [WIDTH-1:0] mem  [NB2][MD];
  logic [PW-1:0]    head [NB2];
  logic [PW-1:0]    tail [NB2];
  logic [OW-1:0]    occ  [NB2];
  logic [SW-1:0]    wr_sel;
  logic [SW-1:0]    rd_sel;

  logic enq_fire;
  logic deq_fire;

  // Handshake and head-of-queue view, derived only from registered state.
  assign enq__RDY   = !RST && (occ[wr_sel] != OW'(DEPTH));
  assign deq__RDY   = !RST && (occ[rd_sel] != OW'(0));
  assign first__RDY = deq__RDY;
  assign first      = deq__RDY ? mem[rd_sel][head[rd_sel]] : '0;

  assign enq_fire = enq__ENA && enq__RDY;
  assign deq_fire = deq__ENA && deq__RDY;

  // Payload storage; contents are never cleared, visibility is gated by occupancy.
  always_ff @(posedge CLK) begin
    if (enq_fire && !flush) begin
      mem[wr_sel][tail[wr_sel]] <= enq_v;
    end
  end

  // Bank selectors, per-bank pointers/occupancy and the global count.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_sel <= '0;
      rd_sel <= '0;
      count  <= '0;
      for (int b = 0; b < NB2; b++) begin
        head[b] <= '0;
        tail[b] <= '0;
        occ[b]  <= '0;
      end
    end else begin
      if (enq_fire) begin
        tail[wr_sel] <= (tail[wr_sel] == PW'(DEPTH-1)) ? '0 : tail[wr_sel] + PW'(1);
        wr_sel       <= (wr_sel == SW'(NBANKS-1)) ? '0 : wr_sel + SW'(1);
      end
      if (deq_fire) begin
        head[rd_sel] <= (head[rd_sel] == PW'(DEPTH-1)) ? '0 : head[rd_sel] + PW'(1);
        rd_sel       <= (rd_sel == SW'(NBANKS-1)) ? '0 : rd_sel + SW'(1);
      end
      for (int b = 0; b < NB2; b++) begin
        if ((enq_fire && (wr_sel == SW'(b))) && !(deq_fire && (rd_sel == SW'(b)))) begin
          occ[b] <= occ[b] + OW'(1);
        end else if (!(enq_fire && (wr_sel == SW'(b))) && (deq_fire && (rd_sel == SW'(b)))) begin
          occ[b] <= occ[b] - OW'(1);
        end
      end
      if (enq_fire && !deq_fire) begin
        count <= count + CW'(1);
      end else if (!enq_fire && deq_fire) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
